// File: rtl/sram_ctrl.sv
// Sequencer between the 32-bit pipeline memory stage and a 16-bit SRAM: each word is two half-word phases.
// Optional one-entry read buffer enabled by defining SRAM_CTRL_RD_BUF_EN.
module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int unsigned PHASE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  inout  wire  [15:0] SRAM_DQ
);

  localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned WW = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [WW-1:0]   r_woff;
  logic [31:0]     r_wdata;
  logic            r_dq_oe;
  logic [15:0]     r_dq_out;
  logic [WW-1:0]   w_woff;
  logic [WW-1:0]   w_woff_sel;
  logic [31:0]     w_wdata_sel;
  logic            w_last;
  logic            w_accept;
  logic            w_hit;
  logic            w_wr_next;
  logic            w_ph_next;
  logic            w_hi_next;

  // Word offset from the SRAM base; anything out of range wraps silently.
  assign w_woff      = WW'((address - BASE_ADDR) >> 2);
  assign w_last      = (r_cnt == CW'(PHASE_CYCLES - 1));
  assign w_accept    = (r_state == S_IDLE) && (rd_en || wr_en);
  assign w_woff_sel  = (r_state == S_IDLE) ? w_woff : r_woff;
  assign w_wdata_sel = (r_state == S_IDLE) ? write_data : r_wdata;
  assign SRAM_DQ     = r_dq_oe ? r_dq_out : 16'hzzzz;

`ifdef SRAM_CTRL_RD_BUF_EN
  logic            r_is_wr;
  logic            r_buf_valid;
  logic [WW-1:0]   r_buf_woff;
  logic [31:0]     r_buf_data;

  assign w_hit = r_buf_valid && (r_buf_woff == w_woff);
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    ready        = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready      = !(rd_en || wr_en);
        w_cnt_next = '0;
        if (wr_en)      w_state_next = S_WR_LO;
        else if (rd_en) w_state_next = w_hit ? S_DONE : S_RD_LO;
      end
      S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI: begin
        if (w_last) begin
          w_cnt_next = '0;
          case (r_state)
            S_RD_LO: w_state_next = S_RD_HI;
            S_WR_LO: w_state_next = S_WR_HI;
            default: w_state_next = S_DONE;
          endcase
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        ready        = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Decode of the upcoming state so the SRAM pins are registered in step with it.
  always_comb begin
    w_wr_next = 1'b0;
    w_ph_next = 1'b0;
    w_hi_next = 1'b0;
    case (w_state_next)
      S_RD_LO: w_ph_next = 1'b1;
      S_RD_HI: begin w_ph_next = 1'b1; w_hi_next = 1'b1; end
      S_WR_LO: begin w_ph_next = 1'b1; w_wr_next = 1'b1; end
      S_WR_HI: begin w_ph_next = 1'b1; w_wr_next = 1'b1; w_hi_next = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_woff    <= '0;
      r_wdata   <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      r_dq_oe   <= 1'b0;
      r_dq_out  <= '0;
    end else begin
      if (w_accept) begin
        r_woff  <= w_woff;
        r_wdata <= write_data;
      end
      if ((r_state == S_RD_LO) && w_last) read_data[15:0]  <= SRAM_DQ;
      if ((r_state == S_RD_HI) && w_last) read_data[31:16] <= SRAM_DQ;
`ifdef SRAM_CTRL_RD_BUF_EN
      if ((r_state == S_IDLE) && !wr_en && rd_en && w_hit) read_data <= r_buf_data;
`endif
      SRAM_WE_N <= !w_wr_next;
      r_dq_oe   <= w_wr_next;
      if (w_ph_next) SRAM_ADDR <= {w_woff_sel, w_hi_next};
      if (w_wr_next) r_dq_out <= w_hi_next ? w_wdata_sel[31:16] : w_wdata_sel[15:0];
    end
  end

`ifdef SRAM_CTRL_RD_BUF_EN
  // Buffer filled by completed reads, kept coherent by writes to the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr     <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_woff  <= '0;
      r_buf_data  <= '0;
    end else begin
      if (w_accept) r_is_wr <= wr_en;
      if (r_state == S_DONE) begin
        if (!r_is_wr) begin
          r_buf_valid <= 1'b1;
          r_buf_woff  <= r_woff;
          r_buf_data  <= read_data;
        end else if (r_buf_valid && (r_buf_woff == r_woff)) begin
          r_buf_data <= r_wdata;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl against a word-level memory model and a behavioural SRAM.
module tb_sram_ctrl;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int          P    = 3;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  wire  [15:0] sram_dq;

  logic [15:0] mem [0:262143];
  bit   [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd;
  bit          buf_valid;
  logic [16:0] buf_woff;
  int          n_checks;
  int          n_fail;

  sram_ctrl #(.BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_DQ(sram_dq)
  );

  // Behavioural SRAM: drives the bus whenever it is not being written.
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_get(input logic [16:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return 32'h0;
  endfunction

  // One word access, started just after a rising edge with the controller idle.
  task automatic run_op(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                        input logic [31:0] data, output int stalls);
    logic [31:0] off;
    logic [16:0] woff;
    bit          hit;
    int          done_cyc;
    off  = addr - BASE;
    woff = off[18:2];
    hit  = 1'b0;
`ifdef SRAM_CTRL_RD_BUF_EN
    hit = !do_wr && buf_valid && (buf_woff == woff);
`endif
    done_cyc   = hit ? 1 : 2 * P + 1;
    wr_en      = do_wr;
    rd_en      = do_rd;
    address    = addr;
    write_data = data;
    stalls     = 0;
    for (int c = 0; c <= done_cyc; c++) begin
      @(negedge clk);
      check_eq("ready", 32'(ready), 32'(c == done_cyc));
      if (!ready) stalls++;
      if (c >= 1 && c < done_cyc) begin
        check_eq("sram_addr", 32'(sram_addr), 32'({woff, (c > P)}));
        check_eq("we_n", 32'(sram_we_n), 32'(!do_wr));
      end else begin
        check_eq("we_n_idle", 32'(sram_we_n), 32'd1);
      end
      if (c == done_cyc) begin
        if (do_wr) check_eq("rd_hold", read_data, last_rd);
        else       check_eq("rd_data", read_data, ref_get(woff));
      end
      @(posedge clk); #1;
      if (c == 0) begin
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = $urandom;
        write_data = $urandom;
      end
    end
    if (do_wr) begin
      ref_mem[int'(woff)] = data;
    end else begin
      last_rd   = ref_get(woff);
      buf_valid = 1'b1;
      buf_woff  = woff;
    end
  endtask

  task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] data);
    logic [16:0] woff;
    logic [31:0] old;
    woff       = 17'((addr - BASE) >> 2);
    old        = ref_get(woff);
    wr_en      = 1'b1;
    address    = addr;
    write_data = data;
    repeat (4) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    check_eq("rstw_we_n_before", 32'(sram_we_n), 32'd0);
    check_eq("rstw_addr_before", 32'(sram_addr), 32'({woff, 1'b1}));
    rst = 1'b1;
    #1;
    check_eq("rstw_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rstw_addr", 32'(sram_addr), 32'd0);
    check_eq("rstw_rdata", read_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rstw_ready", 32'(ready), 32'd1);
    check_eq("rstw_hi_kept", 32'(mem[{woff, 1'b1}]), 32'(old[31:16]));
    check_eq("rstw_lo_new", 32'(mem[{woff, 1'b0}]), 32'(data[15:0]));
    ref_mem[int'(woff)] = {old[31:16], data[15:0]};
    last_rd   = 32'h0;
    buf_valid = 1'b0;
  endtask

  int          s;
  int          total;
  int          exp_total;
  int          kind;
  logic [31:0] a;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    last_rd    = 32'h0;
    buf_valid  = 1'b0;
    buf_woff   = '0;
    rst        = 1'b1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdata", read_data, 32'h0);
    check_eq("rst_addr", 32'(sram_addr), 32'h0);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, s);
    check_eq("wr_stall", 32'(s), 32'(2 * P + 1));
    check_eq("hw0", 32'(mem[0]), 32'h0000BEEF);
    check_eq("hw1", 32'(mem[1]), 32'h0000DEAD);
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, s);
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, s);
`ifdef SRAM_CTRL_RD_BUF_EN
    check_eq("hit_stall", 32'(s), 32'd1);
`else
    check_eq("rd_stall", 32'(s), 32'(2 * P + 1));
`endif

    run_op(1'b1, 1'b1, 32'd1028, 32'h12345678, s);
    check_eq("both_hw2", 32'(mem[2]), 32'h00005678);
    check_eq("both_hw3", 32'(mem[3]), 32'h00001234);
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, s);

    run_op(1'b1, 1'b0, 32'd1024, 32'h0, s);
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, s);

    run_op(1'b1, 1'b0, 32'd1032, $urandom, s);
    run_op(1'b1, 1'b0, 32'd1036, $urandom, s);
    buf_valid = buf_valid;
    total     = 0;
    exp_total = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'd1024 + 32'(4 * i);
`ifdef SRAM_CTRL_RD_BUF_EN
      exp_total += (buf_valid && buf_woff == 17'((a - BASE) >> 2)) ? 1 : 2 * P + 1;
`else
      exp_total += 2 * P + 1;
`endif
      run_op(1'b0, 1'b1, a, 32'h0, s);
      total += s;
    end
    check_eq("b2b_stalls", 32'(total), 32'(exp_total));

    reset_mid_write(32'd1024, 32'hCAFEF00D);
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, s);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      else                           a = BASE + 32'(4 * $urandom_range(0, 7));
      a = a | 32'($urandom_range(0, 3));
      run_op(kind >= 2, kind != 2, a, $urandom, s);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencer between the 32-bit memory stage of the ARM pipeline and the 16-bit off-chip SRAM. Each word access is split into two half-word SRAM phases with fixed wait states. The block holds `ready` low to freeze the pipeline until the word is complete, then returns read data or commits write data.

## Interface
Parameters:
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM word 0.
- `PHASE_CYCLES`, 3: clock cycles per half-word phase (≥1). Must satisfy PHASE_CYCLES × Tclk ≥ SRAM access time (20 ns).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_en` in 1: word read request.
- `wr_en` in 1: word write request.
- `address` in 32: byte address; bits [1:0] ignored.
- `write_data` in 32: write word.
- `read_data` out 32: read word, valid in DONE.
- `ready` out 1: high = pipeline may advance.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write enable, active low.
- `SRAM_DQ` inout 16: SRAM data bus.

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A phase counter (0..PHASE_CYCLES-1) runs in every LO/HI state.
- IDLE: on `wr_en`, go to WR_LO. Otherwise on `rd_en`, go to RD_LO. `wr_en` wins if both are set. `address` and `write_data` are latched on acceptance; input changes during the operation are ignored.
- Offset: off = address − BASE_ADDR, unsigned, modulo 2^32. SRAM_ADDR = {off[18:2], h}, with h=0 in LO phases and h=1 in HI phases. Out-of-range addresses wrap silently.
- RD_LO / RD_HI:
  - SRAM_WE_N=1; SRAM_DQ tri-stated.
  - Sample SRAM_DQ into read_data[15:0] (LO) or read_data[31:16] (HI) at the edge ending the phase's last cycle.
- WR_LO / WR_HI:
  - SRAM_WE_N=0.
  - SRAM_DQ driven with write_data[15:0] (LO) or write_data[31:16] (HI).
- LO → HI → DONE when the counter reaches PHASE_CYCLES-1.
- DONE lasts one cycle, then unconditionally returns to IDLE. read_data holds until the next read completes.
- `ready` is combinational: high in DONE, or in IDLE when neither `rd_en` nor `wr_en` is set. Low otherwise.
- SRAM_ADDR, SRAM_WE_N and the DQ drive/enable are registered.

## Timing
- Reset values:
  - state IDLE, counter 0
  - read_data 0, SRAM_ADDR 0
  - SRAM_WE_N 1, SRAM_DQ high-Z
  - ready 1 when no request is present
- With the request first seen in IDLE at cycle 0:
  - LO phase occupies cycles 1..P.
  - HI phase occupies cycles P+1..2P.
  - DONE is at cycle 2P+1.
  - `ready` is low in cycles 0..2P. For P=3 this gives a 7-cycle stall.
- Back-to-back: a request present in the cycle after DONE is accepted in that IDLE cycle. There are no extra bubbles.
- Reset mid-operation: immediate abort to reset values. SRAM_WE_N rises asynchronously. A partial write may leave the low half-word updated.
- SRAM_DQ is never driven in IDLE, RD_*, or DONE.

## Configuration
- `SRAM_CTRL_RD_BUF_EN` defined: adds a one-entry read buffer holding the word offset, the data, and a valid bit.
  - Read hit (valid, same off[18:2]) in IDLE: go straight to DONE. `ready` is low in cycle 0 only; data comes from the buffer and the SRAM is not touched.
  - Read miss: the buffer is filled at DONE.
  - Write to the same word: the buffer is updated with write_data at DONE.
  - Reset clears valid.
- Not defined: every read performs both SRAM phases. The buffer logic is absent.

## Test plan
- Write 0xDEADBEEF to 1024, P=3 → SRAM half-word 0 = 0xBEEF and half-word 1 = 0xDEAD; WE_N low for cycles 1..6; ready high at cycle 7 only.
- Read 1024 after that write → read_data = 0xDEADBEEF at cycle 7; DQ never driven by the controller during the read.
- `rd_en` and `wr_en` both set at 1028 with data 0x12345678 → write performed (SRAM_ADDR 2, then 3); a following read returns 0x12345678.
- Assert `rst` in cycle 4 of a write → WE_N=1 and DQ high-Z immediately; ready=1 next cycle; half-word 1 unchanged.
- Four back-to-back reads at 1024/1028/1032/1036 → 28 total stalled cycles, each word correct, no idle gaps.
- With `SRAM_CTRL_RD_BUF_EN`: read 1024 twice → second read completes at cycle 1 with identical data; write 0x0 to 1024, then read → 0x00000000 with a 1-cycle hit.
